// File: rtl/sample_input_conditioner_pkg.sv
// Shared definitions for the sample input conditioner and the filter core
// bench: default widths and the median-window fill state.
package sample_input_conditioner_pkg;

  localparam int DATA_W_DEF      = 10;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 16;

  // Number of valid samples held in the 3-tap window.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } fill_e;

endpackage

// File: rtl/sample_input_conditioner_median3.sv
// Combinational median of three unsigned values. Ties return the
// duplicated value naturally because only min/max selections are used.
module sample_input_conditioner_median3 #(
  parameter int DATA_W = sample_input_conditioner_pkg::DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] med
);

  logic [DATA_W-1:0] lo_ab;
  logic [DATA_W-1:0] hi_ab;
  logic [DATA_W-1:0] hi_min;

  // median = max(min(a,b), min(max(a,b), c))
  always_comb begin
    lo_ab  = (a < b) ? a : b;
    hi_ab  = (a < b) ? b : a;
    hi_min = (hi_ab < c) ? hi_ab : c;
    med    = (lo_ab > hi_min) ? lo_ab : hi_min;
  end

endmodule

// File: rtl/sample_input_conditioner.sv
// Front-end for the moving-average filter core: resynchronises the sample
// strobe, turns each rising edge into a one-cycle capture, keeps a 3-deep
// sample window and emits either the newest sample or the window median.
module sample_input_conditioner
  import sample_input_conditioner_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              strobe_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              median_en,
  input  logic              clear,
  output logic [DATA_W-1:0] data_out,
  output logic              strobe_out,
  output logic [CNT_W-1:0]  sample_count
);

  // Synchroniser and edge detect
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   s_prev;
  logic                   edge_det;
  logic                   take;

  // Window, fill state, output pipeline
  logic [2:0][DATA_W-1:0] win;      // win[0] newest
  fill_e                  state_q;
  fill_e                  state_d;
  logic [DATA_W-1:0]      med;
  logic [DATA_W-1:0]      sel_data;
  logic [1:0]             vld_pipe; // [0] captured this cycle, [1] strobe_out

  // Shift strobe_in through the synchroniser chain; runs regardless of ena
  // so a re-enable with the strobe already high sees no fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_in};
      s_prev <= s_sync;
    end
  end

  assign s_sync   = sync_q[SYNC_STAGES-1];
  assign edge_det = s_sync & ~s_prev & ena;
  // clear has priority: a coinciding edge is dropped entirely.
  assign take     = edge_det & ~clear;

  // Fill state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Fill state next-state: count up to FULL on accepted samples, flush on clear
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = EMPTY;
    end else if (edge_det) begin
      unique case (state_q)
        EMPTY:   state_d = ONE;
        ONE:     state_d = TWO;
        TWO:     state_d = FULL;
        FULL:    state_d = FULL;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Sample window shift on capture; clear zeroes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (clear) begin
      win <= '0;
    end else if (take) begin
      win <= {win[1], win[0], data_in};
    end
  end

  // Accepted-sample counter, free-running wrap; clear leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sample_count <= '0;
    else if (take) sample_count <= sample_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  sample_input_conditioner_median3 #(.DATA_W(DATA_W)) u_median3 (
    .a   (win[0]),
    .b   (win[1]),
    .c   (win[2]),
    .med (med)
  );

  // Output select: median only once the window holds three real samples
  always_comb begin
    sel_data = win[0];
    if (median_en && (state_q == FULL)) sel_data = med;
  end

  // Capture-to-output valid pipeline. A clear landing between capture and
  // output flushes the pending sample as well, so no zeroed window leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[0] & ~clear, take};
  end

  // Output register, loaded only alongside the strobe so it holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     data_out <= '0;
    else if (vld_pipe[0] && !clear) data_out <= sel_data;
  end

  assign strobe_out = vld_pipe[1];

endmodule

// File: tb/tb_sample_input_conditioner.sv
// Randomised bench for sample_input_conditioner with a queue-based model of
// accepted samples; counter built narrow so wrap-around is reachable.
module tb_sample_input_conditioner;

  localparam int DATA_W      = 10;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int LAT         = SYNC_STAGES + 2; // posedges from first sample to pulse

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic              strobe_in = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              median_en = 1'b0;
  logic              clear = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              strobe_out;
  logic [CNT_W-1:0]  sample_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int hist[$];     // samples accepted since last clear/reset
  int acc = 0;     // total accepted since reset
  int last_out = 0;

  always #5 clk = ~clk;

  sample_input_conditioner #(
    .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .strobe_in    (strobe_in),
    .data_in      (data_in),
    .median_en    (median_en),
    .clear        (clear),
    .data_out     (data_out),
    .strobe_out   (strobe_out),
    .sample_count (sample_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int median_of(input int a, input int b, input int c);
    int q[$];
    q = {a, b, c};
    q.sort();
    return q[1];
  endfunction

  // One strobe_in rise carrying sample d. do_clr pulses clear on the edge
  // cycle; ena_off keeps ena low over the rise, re-enabling while still high.
  task automatic send(input int d, input bit med, input int hold, input int gap,
                      input bit do_clr, input bit ena_off);
    int  npulse = 0;
    int  first = -1;
    int  pdata = 0;
    int  exp_out = 0;
    bit  accepted;
    accepted = !do_clr && !ena_off;
    if (do_clr) hist.delete();
    if (accepted) begin
      hist.push_back(d);
      acc++;
      if (med && hist.size() >= 3)
        exp_out = median_of(hist[hist.size()-1], hist[hist.size()-2], hist[hist.size()-3]);
      else
        exp_out = d;
    end
    @(negedge clk);
    data_in   = DATA_W'(d);
    strobe_in = 1'b1;
    median_en = med;
    ena       = !ena_off;
    for (int i = 1; i <= hold + gap; i++) begin
      @(posedge clk); #1;
      if (strobe_out) begin
        npulse++;
        if (first < 0) first = i;
        pdata = int'(data_out);
      end
      if (i == hold) strobe_in = 1'b0;
      if (do_clr && i == SYNC_STAGES) clear = 1'b1;
      if (do_clr && i == SYNC_STAGES + 1) clear = 1'b0;
      if (ena_off && i == SYNC_STAGES + 4) ena = 1'b1;
    end
    chk("pulse_count", npulse, accepted ? 1 : 0);
    if (accepted) begin
      chk("latency", first, LAT);
      chk("data", pdata, exp_out);
      last_out = exp_out;
    end
    chk("data_hold", data_out, last_out);
    chk("count", sample_count, acc % (1 << CNT_W));
  endtask

  task automatic clear_only();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    hist.delete();
  endtask

  initial begin
    int d, hold, gap;
    bit c, eo;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobe", strobe_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_count", sample_count, 0);
    @(negedge clk); rst_n = 1'b1; ena = 1'b1;

    // First sample after reset is bypassed even with median enabled
    send(512, 1, 6, 6, 0, 0);

    // Median stream
    clear_only();
    send(100, 1, 5, 6, 0, 0);
    send(900, 1, 5, 6, 0, 0);
    send(110, 1, 5, 6, 0, 0);
    send(120, 1, 5, 6, 0, 0);

    // Same stream bypassed
    clear_only();
    send(100, 0, 5, 6, 0, 0);
    send(900, 0, 5, 6, 0, 0);
    send(110, 0, 5, 6, 0, 0);
    send(120, 0, 5, 6, 0, 0);

    // Long high strobe, then a rise with ena low
    send(333, 0, 40, 6, 0, 0);
    send(444, 1, 12, 6, 0, 1);

    // Clear coincident with edge after FULL, then 7,8,9
    send(1, 1, 5, 6, 0, 0);
    send(2, 1, 5, 6, 0, 0);
    send(3, 1, 5, 6, 0, 0);
    send(55, 1, 6, 6, 1, 0);
    send(7, 1, 5, 6, 0, 0);
    send(8, 1, 5, 6, 0, 0);
    send(9, 1, 5, 6, 0, 0);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      d    = int'($urandom_range(0, (1 << DATA_W) - 1));
      c    = ($urandom_range(0, 9) == 0);
      eo   = !c && ($urandom_range(0, 9) == 0);
      hold = eo ? int'($urandom_range(8, 20)) : int'($urandom_range(1, 20));
      gap  = int'($urandom_range(5, 10));
      if (hold + gap < 8) gap = 8 - hold;
      send(d, 1'($urandom_range(0, 1)), hold, gap, c, eo);
    end

    // Counter wrap
    while ((acc % (1 << CNT_W)) != (1 << CNT_W) - 1)
      send(int'($urandom_range(0, 1023)), 0, 4, 6, 0, 0);
    send(77, 0, 4, 6, 0, 0);
    chk("wrap", sample_count, 0);

    // Async reset between capture and pulse
    @(negedge clk);
    data_in = 10'd600; strobe_in = 1'b1; median_en = 1'b1;
    for (int i = 1; i <= LAT - 1; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_strobe", strobe_out, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_count", sample_count, 0);
    strobe_in = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_hold", strobe_out, 0);
    end
    hist.delete(); acc = 0; last_out = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    clear_only();
    send(500, 1, 5, 6, 0, 0);
    send(20, 1, 5, 6, 0, 0);
    send(300, 1, 5, 6, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
